fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- RV32I instruction-fetch stage, directly upstream of the combinational byte-addressed, little-endian instruction memory.
- Owns the program counter and drives the fetch address to the memory.
- Captures the returned 32-bit instruction with its PC into the IF/ID pipeline register for decode.
- Handles stall, branch/jump redirect, boot bubble and fetch-fault trapping.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 256, byte size of instruction memory; fetches at or beyond this bound fault.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID when invalid.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- stall  input  1  hazard unit: hold PC and IF/ID contents.
- redirect  input  1  branch/jump taken; load PC from redirect_pc.
- redirect_pc  input  32  branch/jump target address.
- imem_addr  output  32  fetch address to instruction memory; always equals the current PC.
- imem_instr  input  32  instruction word from memory; combinational, same cycle as imem_addr.
- instr_d  output  32  IF/ID instruction.
- pc_d  output  32  IF/ID PC of instr_d.
- pc_plus4_d  output  32  IF/ID pc_d+4, for JAL/JALR link.
- valid_d  output  1  IF/ID holds a real instruction.
- fetch_fault  output  1  sticky: misaligned or out-of-range fetch detected.

Behaviour:
- Reset (rst=1 at a rising edge), regardless of state:
  - pc <= RESET_PC; state <= BOOT.
  - instr_d <= NOP_INSTR; pc_d <= 0; pc_plus4_d <= 0; valid_d <= 0; fetch_fault <= 0.
- Reset mid-operation discards any pending redirect or stall.
- States and transitions:
  - BOOT: one cycle, IF/ID stays a bubble; pc unchanged; -> RUN. Avoids latching memory output during initial load.
  - RUN: normal fetch.
  - FAULT: absorbing until rst.
- RUN priority per edge: redirect > stall > advance.
  - Advance: IF/ID <= {imem_instr, pc, pc+4}; valid_d <= 1; pc <= pc+4 (mod 2^32).
  - Stall (redirect=0): pc and all IF/ID registers hold.
  - Redirect, stall ignored: pc <= redirect_pc; IF/ID <= bubble (instr_d=NOP_INSTR, valid_d=0). The wrong-path instruction is squashed.
  - Redirect during BOOT: pc <= redirect_pc; still -> RUN next cycle.
- Fault check (RUN, combinational on current pc):
  - Fault when pc[1:0]!=0 or pc > IMEM_BYTES-4.
  - On fault edge: state <= FAULT; fetch_fault <= 1; IF/ID <= bubble; pc holds the faulting value.
  - Fault takes priority over stall but not over redirect: a redirect that same cycle overrides, no fault is latched, and the new pc is checked next cycle.
- FAULT: pc, IF/ID bubble and fetch_fault=1 hold; stall and redirect ignored.
- Fetch-to-decode latency: instr_d visible one cycle after its PC is on imem_addr.
- Width rules: pc+4 is a 32-bit add, carry discarded; wrap at 32'hFFFF_FFFC produces 0. The out-of-range rule normally faults first.

Decomposition:
- Shared package fetch_pkg:
  - Typedef fetch_state_t {BOOT, RUN, FAULT}.
  - Constant NOP_INSTR.
  - Packed struct if_id_t {instr, pc, pc_plus4, valid}, reused by the decode stage.
- One sub-module, if_id_reg: the pipeline register with enable (~stall) and synchronous flush. It resets to the bubble, and flush has priority over enable.
- PC, next-PC mux, fault check and FSM stay in fetch_stage.

Test Plan:
- Reset release with memory bytes 0..7 = 93 00 10 00 13 01 20 00:
  - First edge after rst low: imem_addr=0, valid_d=0 (BOOT).
  - Second edge: instr_d=32'h0010_0093, pc_d=0, pc_plus4_d=4, valid_d=1.
  - Third edge: instr_d=32'h0020_0113, pc_d=4.
- Stall held 3 cycles at pc=8: imem_addr stays 8; instr_d/pc_d/valid_d unchanged; after release the next edge captures pc_d=8.
- redirect=1, redirect_pc=32'h40, stall=1 simultaneously at pc=12:
  - Next cycle: imem_addr=32'h40, valid_d=0, instr_d=32'h13.
  - Following edge: pc_d=32'h40, valid_d=1.
- redirect_pc=32'h42:
  - One cycle later: fetch_fault=1, valid_d=0, imem_addr=32'h42.
  - Subsequent redirect/stall have no effect.
  - rst clears: fetch_fault=0, pc=RESET_PC.
- Sequential fetch reaching pc=32'hFC with IMEM_BYTES=256:
  - The fetch at FC is valid.
  - pc=32'h100 then faults: fetch_fault=1, imem_addr holds 32'h100.
- rst asserted mid-stall with pending redirect: next edge pc=RESET_PC, valid_d=0, state BOOT; redirect ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM states, bubble encoding and the IF/ID payload
// consumed by the decode stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, instruction-memory port and
// IF/ID contents out. master is the fetch stage, slave is its environment.
interface fetch_stage_if;

    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        fetch_fault;

    modport master (
        input  stall, redirect, redirect_pc, imem_instr,
        output imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, fetch_fault
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_instr,
        input  imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, fetch_fault
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: loads on enable, flush forces a bubble and wins
// over enable; reset also leaves a bubble.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0013
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en_i,
    input  logic   flush_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t bubble_s;
    if_id_t data_q;

    assign bubble_s = '{instr: BUBBLE_INSTR, pc: 32'd0, pc_plus4: 32'd0, valid: 1'b0};

    // Pipeline register with flush priority over enable
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= bubble_s;
        end else if (flush_i) begin
            data_q <= bubble_s;
        end else if (en_i) begin
            data_q <= d_i;
        end else begin
            data_q <= data_q;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: program counter, next-PC selection, fetch-fault trap and
// BOOT/RUN/FAULT control feeding the IF/ID register.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 256,
    parameter logic [31:0] NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
    input logic           clk,
    input logic           rst,
    fetch_stage_if.master bus
);

    // Highest word-aligned address still fully inside instruction memory.
    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, next_pc_d;
    logic         fault_q, fault_d;
    logic [31:0]  pc_plus4_s;
    logic         bad_pc_s;
    logic         ifid_en_s;
    logic         ifid_flush_s;
    if_id_t       ifid_in_s;
    if_id_t       ifid_out_s;

    assign pc_plus4_s = pc_q + 32'd4;
    assign bad_pc_s   = (pc_q[1:0] != 2'b00) || (pc_q > LAST_PC);

    // Next-state, next-PC and IF/ID control
    always_comb begin
        state_d      = state_q;
        next_pc_d    = pc_q;
        fault_d      = fault_q;
        ifid_en_s    = 1'b0;
        ifid_flush_s = 1'b0;
        case (state_q)
            BOOT: begin
                state_d      = RUN;
                ifid_flush_s = 1'b1;
                if (bus.redirect) begin
                    next_pc_d = bus.redirect_pc;
                end else begin
                    next_pc_d = pc_q;
                end
            end
            RUN: begin
                // A same-cycle redirect replaces the faulting PC before it traps.
                if (bus.redirect) begin
                    next_pc_d    = bus.redirect_pc;
                    ifid_flush_s = 1'b1;
                end else if (bad_pc_s) begin
                    state_d      = FAULT;
                    fault_d      = 1'b1;
                    ifid_flush_s = 1'b1;
                end else if (bus.stall) begin
                    next_pc_d = pc_q;
                end else begin
                    next_pc_d = pc_plus4_s;
                    ifid_en_s = 1'b1;
                end
            end
            FAULT: begin
                ifid_flush_s = 1'b1;
            end
            default: begin
                state_d      = BOOT;
                ifid_flush_s = 1'b1;
            end
        endcase
    end

    // PC, fault flag and FSM state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= next_pc_d;
            fault_q <= fault_d;
        end
    end

    assign ifid_in_s = '{instr: bus.imem_instr, pc: pc_q, pc_plus4: pc_plus4_s, valid: 1'b1};

    if_id_reg #(
        .BUBBLE_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk    (clk),
        .rst    (rst),
        .en_i   (ifid_en_s),
        .flush_i(ifid_flush_s),
        .d_i    (ifid_in_s),
        .q_o    (ifid_out_s)
    );

    assign bus.imem_addr   = pc_q;
    assign bus.instr_d     = ifid_out_s.instr;
    assign bus.pc_d        = ifid_out_s.pc;
    assign bus.pc_plus4_d  = ifid_out_s.pc_plus4;
    assign bus.valid_d     = ifid_out_s.valid;
    assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 256-byte little-endian memory model.
module tb_fetch_stage;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [7:0] mem [256];

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_BYTES(256),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational little-endian memory read; out-of-range reads return zero.
    always_comb begin
        bus.imem_instr = 32'd0;
        if (bus.imem_addr <= 32'd252) begin
            bus.imem_instr = {mem[bus.imem_addr[7:0] + 8'd3], mem[bus.imem_addr[7:0] + 8'd2],
                              mem[bus.imem_addr[7:0] + 8'd1], mem[bus.imem_addr[7:0]]};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'd0;
        step();
        step();
        checks++;
        if (bus.imem_addr !== 32'd0 || bus.valid_d !== 1'b0 || bus.instr_d !== 32'h13 ||
            bus.pc_d !== 32'd0 || bus.pc_plus4_d !== 32'd0 || bus.fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: addr=%h valid=%b instr=%h pc_d=%h p4=%h fault=%b required 0/0/13/0/0/0",
                     bus.imem_addr, bus.valid_d, bus.instr_d, bus.pc_d, bus.pc_plus4_d, bus.fetch_fault);
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus.imem_addr !== 32'd0 || bus.valid_d !== 1'b0) begin
            failures++;
            $display("FAIL boot_bubble: addr=%h valid=%b required 0/0", bus.imem_addr, bus.valid_d);
        end
        step();
        checks++;
        if (bus.instr_d !== 32'h0010_0093 || bus.pc_d !== 32'd0 || bus.pc_plus4_d !== 32'd4 ||
            bus.valid_d !== 1'b1 || bus.imem_addr !== 32'd4) begin
            failures++;
            $display("FAIL first_fetch: instr=%h pc_d=%h p4=%h valid=%b addr=%h required 00100093/0/4/1/4",
                     bus.instr_d, bus.pc_d, bus.pc_plus4_d, bus.valid_d, bus.imem_addr);
        end
        step();
        checks++;
        if (bus.instr_d !== 32'h0020_0113 || bus.pc_d !== 32'd4 || bus.pc_plus4_d !== 32'd8 ||
            bus.imem_addr !== 32'd8) begin
            failures++;
            $display("FAIL second_fetch: instr=%h pc_d=%h p4=%h addr=%h required 00200113/4/8/8",
                     bus.instr_d, bus.pc_d, bus.pc_plus4_d, bus.imem_addr);
        end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.imem_addr !== 32'd8 || bus.instr_d !== 32'h0020_0113 || bus.pc_d !== 32'd4 ||
                bus.valid_d !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold[%0d]: addr=%h instr=%h pc_d=%h valid=%b required 8/00200113/4/1",
                         i, bus.imem_addr, bus.instr_d, bus.pc_d, bus.valid_d);
            end
        end
        bus.stall = 1'b0;
        step();
        checks++;
        if (bus.pc_d !== 32'd8 || bus.instr_d !== 32'hA000_0008 || bus.imem_addr !== 32'd12) begin
            failures++;
            $display("FAIL stall_release: pc_d=%h instr=%h addr=%h required 8/a0000008/c",
                     bus.pc_d, bus.instr_d, bus.imem_addr);
        end
    endtask

    task automatic test_redirect();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h40;
        bus.stall = 1'b1;
        step();
        checks++;
        if (bus.imem_addr !== 32'h40 || bus.valid_d !== 1'b0 || bus.instr_d !== 32'h13) begin
            failures++;
            $display("FAIL redirect_squash: addr=%h valid=%b instr=%h required 40/0/13",
                     bus.imem_addr, bus.valid_d, bus.instr_d);
        end
        bus.redirect = 1'b0;
        bus.stall = 1'b0;
        step();
        checks++;
        if (bus.pc_d !== 32'h40 || bus.valid_d !== 1'b1 || bus.instr_d !== 32'hA000_0040 ||
            bus.imem_addr !== 32'h44) begin
            failures++;
            $display("FAIL redirect_target: pc_d=%h valid=%b instr=%h addr=%h required 40/1/a0000040/44",
                     bus.pc_d, bus.valid_d, bus.instr_d, bus.imem_addr);
        end
    endtask

    task automatic test_misaligned_fault();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h42;
        step();
        checks++;
        if (bus.imem_addr !== 32'h42 || bus.fetch_fault !== 1'b0 || bus.valid_d !== 1'b0) begin
            failures++;
            $display("FAIL misalign_redirect: addr=%h fault=%b valid=%b required 42/0/0",
                     bus.imem_addr, bus.fetch_fault, bus.valid_d);
        end
        bus.redirect = 1'b0;
        step();
        checks++;
        if (bus.fetch_fault !== 1'b1 || bus.valid_d !== 1'b0 || bus.imem_addr !== 32'h42) begin
            failures++;
            $display("FAIL misalign_trap: fault=%b valid=%b addr=%h required 1/0/42",
                     bus.fetch_fault, bus.valid_d, bus.imem_addr);
        end
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0;
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.fetch_fault !== 1'b1 || bus.valid_d !== 1'b0 || bus.imem_addr !== 32'h42 ||
                bus.instr_d !== 32'h13) begin
                failures++;
                $display("FAIL fault_absorb[%0d]: fault=%b valid=%b addr=%h instr=%h required 1/0/42/13",
                         i, bus.fetch_fault, bus.valid_d, bus.imem_addr, bus.instr_d);
            end
        end
        bus.redirect = 1'b0;
        bus.stall = 1'b0;
        rst = 1'b1;
        step();
        checks++;
        if (bus.fetch_fault !== 1'b0 || bus.imem_addr !== 32'd0) begin
            failures++;
            $display("FAIL fault_clear: fault=%b addr=%h required 0/0", bus.fetch_fault, bus.imem_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_boundary();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hF0;
        step();
        checks++;
        if (bus.imem_addr !== 32'hF0 || bus.valid_d !== 1'b0) begin
            failures++;
            $display("FAIL boot_redirect: addr=%h valid=%b required f0/0", bus.imem_addr, bus.valid_d);
        end
        bus.redirect = 1'b0;
        step();
        step();
        step();
        step();
        checks++;
        if (bus.pc_d !== 32'hFC || bus.valid_d !== 1'b1 || bus.instr_d !== 32'hA000_00FC ||
            bus.pc_plus4_d !== 32'h100 || bus.imem_addr !== 32'h100 || bus.fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL last_word: pc_d=%h valid=%b instr=%h p4=%h addr=%h fault=%b required fc/1/a00000fc/100/100/0",
                     bus.pc_d, bus.valid_d, bus.instr_d, bus.pc_plus4_d, bus.imem_addr, bus.fetch_fault);
        end
        step();
        checks++;
        if (bus.fetch_fault !== 1'b1 || bus.valid_d !== 1'b0 || bus.imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL range_trap: fault=%b valid=%b addr=%h required 1/0/100",
                     bus.fetch_fault, bus.valid_d, bus.imem_addr);
        end
        step();
        checks++;
        if (bus.fetch_fault !== 1'b1 || bus.imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL range_hold: fault=%b addr=%h required 1/100", bus.fetch_fault, bus.imem_addr);
        end
    endtask

    task automatic test_reset_mid_stall();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (bus.imem_addr !== 32'd4 || bus.valid_d !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_run: addr=%h valid=%b required 4/1", bus.imem_addr, bus.valid_d);
        end
        bus.stall = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h80;
        rst = 1'b1;
        step();
        checks++;
        if (bus.imem_addr !== 32'd0 || bus.valid_d !== 1'b0 || bus.instr_d !== 32'h13) begin
            failures++;
            $display("FAIL reset_mid_stall: addr=%h valid=%b instr=%h required 0/0/13",
                     bus.imem_addr, bus.valid_d, bus.instr_d);
        end
        rst = 1'b0;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        step();
        checks++;
        if (bus.imem_addr !== 32'd0 || bus.valid_d !== 1'b0) begin
            failures++;
            $display("FAIL reboot_bubble: addr=%h valid=%b required 0/0", bus.imem_addr, bus.valid_d);
        end
        step();
        checks++;
        if (bus.pc_d !== 32'd0 || bus.valid_d !== 1'b1 || bus.instr_d !== 32'h0010_0093) begin
            failures++;
            $display("FAIL reboot_fetch: pc_d=%h valid=%b instr=%h required 0/1/00100093",
                     bus.pc_d, bus.valid_d, bus.instr_d);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int a = 8; a < 256; a += 4) begin
            mem[a]     = 8'(a);
            mem[a + 1] = 8'h00;
            mem[a + 2] = 8'h00;
            mem[a + 3] = 8'hA0;
        end
        mem[0] = 8'h93; mem[1] = 8'h00; mem[2] = 8'h10; mem[3] = 8'h00;
        mem[4] = 8'h13; mem[5] = 8'h01; mem[6] = 8'h20; mem[7] = 8'h00;
        test_reset();
        test_stall();
        test_redirect();
        test_misaligned_fault();
        test_boundary();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
